abs_diff_accum: RTL and testbench

ABS_DIFF_ACCUM -- requirements
Module: abs_diff_accum

---
 rtl/abs_diff_pkg.sv | 15 +
 rtl/abs_diff_unit.sv | 17 +
 rtl/abs_diff_accum.sv | 141 ++++++++++++++
 tb/tb_abs_diff_accum.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/abs_diff_pkg.sv
// Shared definitions for the absolute-difference accumulator.
//   state_e        : frame FSM state (ACCUM collects samples, HOLD presents the result)
//   DEF_DATA_W     : default operand width
//   DEF_FRAME_LEN  : default number of samples per frame
package abs_diff_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  localparam int DEF_DATA_W    = 7;
  localparam int DEF_FRAME_LEN = 16;

endpackage : abs_diff_pkg

// File: rtl/abs_diff_unit.sv
// Combinational unsigned absolute difference |a - b|.
//   a_i, b_i : unsigned operands (DATA_W bits)
//   diff_o   : |a_i - b_i|, never wraps, 0 for equal operands
module abs_diff_unit
  import abs_diff_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] diff_o
);

  // Subtract the smaller operand from the larger so the result always fits.
  assign diff_o = (a_i >= b_i) ? (a_i - b_i) : (b_i - a_i);

endmodule : abs_diff_unit

// File: rtl/abs_diff_accum.sv
// Frame accumulator of per-sample absolute differences.
// A sample (num_a, num_b) is taken on in_valid && in_ready. Each accepted sample
// produces a registered diff one cycle later and adds it to a running sum. A
// frame closes on the FRAME_LEN-th sample or on a sample marked in_last; the
// block then holds sum/sum_count with sum_valid until sum_ready is seen.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid, in_ready  : input handshake
//   num_a, num_b        : unsigned operands
//   in_last             : accepted sample closes the frame early
//   diff_valid, diff    : per-sample |num_a - num_b|, one-cycle pulse
//   sum_valid, sum_ready: result handshake
//   sum, sum_count      : frame total and number of samples in it
//   max_diff            : largest diff of the frame (only with ABS_DIFF_ACCUM_MAX_EN)
// Optional feature macro: ABS_DIFF_ACCUM_MAX_EN
module abs_diff_accum
  import abs_diff_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int FRAME_LEN = DEF_FRAME_LEN,
  localparam int CNT_W    = $clog2(FRAME_LEN + 1),
  localparam int SUM_W    = DATA_W + CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] num_a,
  input  logic [DATA_W-1:0] num_b,
  input  logic              in_last,
  output logic              diff_valid,
  output logic [DATA_W-1:0] diff,
  output logic              sum_valid,
  input  logic              sum_ready,
  output logic [SUM_W-1:0]  sum,
`ifdef ABS_DIFF_ACCUM_MAX_EN
  output logic [DATA_W-1:0] max_diff,
`endif
  output logic [CNT_W-1:0]  sum_count
);

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  abs_d;
  logic [DATA_W-1:0]  diff_q;
  logic               diff_valid_q;
  logic [SUM_W-1:0]   acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               accept;
  logic               frame_end;
  logic               release_frame;

  abs_diff_unit #(.DATA_W(DATA_W)) u_abs (
    .a_i    (num_a),
    .b_i    (num_b),
    .diff_o (abs_d)
  );

  assign accept        = in_valid && in_ready;
  // The sample being accepted now is the last one if the count already holds FRAME_LEN-1.
  assign frame_end     = accept && (in_last || (cnt_q == CNT_W'(FRAME_LEN - 1)));
  assign release_frame = sum_valid && sum_ready;

  // ---------------- FSM: state register ----------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ACCUM;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  // NOTE: every signal driven in always_comb gets a default first so no
  // path leaves it unassigned (which would infer a latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACCUM:   if (frame_end)     state_d = HOLD;
      HOLD:    if (release_frame) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    in_ready  = 1'b0;
    sum_valid = 1'b0;
    unique case (state_q)
      ACCUM:   in_ready  = 1'b1;
      HOLD:    sum_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  // Per-sample diff: a one-cycle pulse after each acceptance; value retained otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_valid_q <= 1'b0;
      diff_q       <= '0;
    end else begin
      diff_valid_q <= accept;
      if (accept) diff_q <= abs_d;
    end
  end

  // Accumulator and count; only accepted samples (ACCUM only) change them, and
  // the result handshake clears them so the next frame starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (release_frame) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (accept) begin
      acc_q <= acc_q + SUM_W'(abs_d);
      cnt_q <= cnt_q + 1'b1;
    end
  end

`ifdef ABS_DIFF_ACCUM_MAX_EN
  logic [DATA_W-1:0] max_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q <= '0;
    end else if (release_frame) begin
      max_q <= '0;
    end else if (accept && (abs_d > max_q)) begin
      max_q <= abs_d;
    end
  end

  assign max_diff = max_q;
`endif

  assign diff_valid = diff_valid_q;
  assign diff       = diff_q;
  assign sum        = acc_q;
  assign sum_count  = cnt_q;

endmodule : abs_diff_accum

// File: tb/tb_abs_diff_accum.sv
// Directed self-checking bench for abs_diff_accum with DATA_W=7, FRAME_LEN=4.
// Also checks max_diff when built with ABS_DIFF_ACCUM_MAX_EN.
module tb_abs_diff_accum;

  localparam int DATA_W    = 7;
  localparam int FRAME_LEN = 4;
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);
  localparam int SUM_W     = DATA_W + CNT_W;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] num_a;
  logic [DATA_W-1:0] num_b;
  logic              in_last;
  logic              diff_valid;
  logic [DATA_W-1:0] diff;
  logic              sum_valid;
  logic              sum_ready;
  logic [SUM_W-1:0]  sum;
  logic [CNT_W-1:0]  sum_count;
`ifdef ABS_DIFF_ACCUM_MAX_EN
  logic [DATA_W-1:0] max_diff;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  abs_diff_accum #(.DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .num_a      (num_a),
    .num_b      (num_b),
    .in_last    (in_last),
    .diff_valid (diff_valid),
    .diff       (diff),
    .sum_valid  (sum_valid),
    .sum_ready  (sum_ready),
    .sum        (sum),
`ifdef ABS_DIFF_ACCUM_MAX_EN
    .max_diff   (max_diff),
`endif
    .sum_count  (sum_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Present one sample for one cycle, then check the registered diff pulse.
  task automatic send(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                      input logic last, input logic [31:0] exp_d);
    @(negedge clk);
    num_a = a; num_b = b; in_last = last; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    check("diff_valid", 32'(diff_valid), 1);
    check("diff", 32'(diff), exp_d);
  endtask

  // Complete the result handshake and check the block is back in ACCUM, cleared.
  task automatic release_result(input string tag);
    @(negedge clk);
    sum_ready = 1'b1;
    @(posedge clk); #1;
    sum_ready = 1'b0;
    check({tag, "_sum_valid"}, 32'(sum_valid), 0);
    check({tag, "_in_ready"},  32'(in_ready), 1);
    check({tag, "_sum_clr"},   32'(sum), 0);
    check({tag, "_cnt_clr"},   32'(sum_count), 0);
`ifdef ABS_DIFF_ACCUM_MAX_EN
    check({tag, "_max_clr"},   32'(max_diff), 0);
`endif
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; sum_ready = 1'b0;
    num_a = '0; num_b = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_diff_valid", 32'(diff_valid), 0);
    check("rst_diff",       32'(diff), 0);
    check("rst_sum_valid",  32'(sum_valid), 0);
    check("rst_sum",        32'(sum), 0);
    check("rst_sum_count",  32'(sum_count), 0);
`ifdef ABS_DIFF_ACCUM_MAX_EN
    check("rst_max", 32'(max_diff), 0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", 32'(in_ready), 1);

    // Basic frame: diffs 7,7,127,0 -> 141 over 4 samples
    send(7'd10, 7'd3,   1'b0, 7);
    check("f1_no_sum_yet", 32'(sum_valid), 0);
    @(posedge clk); #1;
    check("f1_diff_pulse_drops", 32'(diff_valid), 0);
    send(7'd3,  7'd10,  1'b0, 7);
    send(7'd0,  7'd127, 1'b0, 127);
    check("f1_not_closed_at_3", 32'(sum_valid), 0);
    send(7'd5,  7'd5,   1'b0, 0);
    check("f1_sum_valid", 32'(sum_valid), 1);
    check("f1_sum",       32'(sum), 141);
    check("f1_count",     32'(sum_count), 4);
    check("f1_in_ready",  32'(in_ready), 0);
    release_result("f1");

    // Worst-case frame: 4 x 127 = 508 must not wrap
    for (int i = 0; i < 4; i++) send(7'd127, 7'd0, 1'b0, 127);
    check("f2_sum_valid", 32'(sum_valid), 1);
    check("f2_sum",       32'(sum), 508);
    check("f2_count",     32'(sum_count), 4);
    release_result("f2");

    // One-sample frame via in_last, then back-pressure with in_valid held high
    send(7'd9, 7'd2, 1'b1, 7);
    check("f3_sum_valid", 32'(sum_valid), 1);
    check("f3_sum",       32'(sum), 7);
    check("f3_count",     32'(sum_count), 1);
    @(negedge clk);
    num_a = 7'd100; num_b = 7'd0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold_in_ready",  32'(in_ready), 0);
      check("hold_sum_valid", 32'(sum_valid), 1);
      check("hold_sum",       32'(sum), 7);
      check("hold_count",     32'(sum_count), 1);
      check("hold_no_accept", 32'(diff_valid), 0);
    end
    @(negedge clk);
    sum_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; sum_ready = 1'b0;
    check("hold_rel_in_ready",  32'(in_ready), 1);
    check("hold_rel_sum_valid", 32'(sum_valid), 0);
    check("hold_rel_no_accept", 32'(diff_valid), 0);
    check("hold_rel_sum",       32'(sum), 0);

    // Next frame starts from zero: diffs 1,3,0,6 -> 10
    send(7'd2, 7'd1, 1'b0, 1);
    send(7'd4, 7'd1, 1'b0, 3);
    send(7'd3, 7'd3, 1'b0, 0);
    send(7'd0, 7'd6, 1'b0, 6);
    check("f4_sum",   32'(sum), 10);
    check("f4_count", 32'(sum_count), 4);
    release_result("f4");

    // Reset in mid-frame discards the partial frame immediately
    send(7'd10, 7'd0, 1'b0, 10);
    send(7'd0,  7'd20, 1'b0, 20);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_diff_valid", 32'(diff_valid), 0);
    check("mid_rst_diff",       32'(diff), 0);
    check("mid_rst_sum_valid",  32'(sum_valid), 0);
    check("mid_rst_sum",        32'(sum), 0);
    check("mid_rst_count",      32'(sum_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    send(7'd1, 7'd0, 1'b0, 1);
    send(7'd2, 7'd0, 1'b0, 2);
    check("f5_not_closed_at_2", 32'(sum_valid), 0);
    send(7'd3, 7'd0, 1'b0, 3);
    check("f5_not_closed_at_3", 32'(sum_valid), 0);
    send(7'd4, 7'd0, 1'b0, 4);
    check("f5_sum_valid", 32'(sum_valid), 1);
    check("f5_sum",       32'(sum), 10);
    check("f5_count",     32'(sum_count), 4);
    release_result("f5");

    // Mixed frame: diffs 8,20,0,2 -> sum 30, largest 20
    send(7'd1,  7'd9,  1'b0, 8);
    send(7'd20, 7'd0,  1'b0, 20);
    send(7'd4,  7'd4,  1'b0, 0);
    send(7'd50, 7'd48, 1'b0, 2);
    check("f6_sum",   32'(sum), 30);
    check("f6_count", 32'(sum_count), 4);
`ifdef ABS_DIFF_ACCUM_MAX_EN
    check("f6_max", 32'(max_diff), 20);
    repeat (2) @(posedge clk);
    #1;
    check("f6_max_stable", 32'(max_diff), 20);
`endif
    release_result("f6");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_abs_diff_accum
